// File: rtl/intt_result_collector.sv
// Collects INTT result bundles into a local buffer over one transform and
// drains them as a single valid/ready stream of 30-bit coefficients.
module intt_result_collector #(
   parameter int LOG_CORE_COUNT = 4,
   parameter int LOG_N          = 12
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][59:0]  in_data,
   input  logic [8:0]                                 in_address,
   input  logic                                       in_active,
   output logic                                       collect_ready,
   output logic [29:0]                                m_data,
   output logic                                       m_valid,
   input  logic                                       m_ready,
   output logic                                       m_last,
   output logic                                       overrun,
   output logic                                       addr_error
);

   localparam int CORES   = 1 << LOG_CORE_COUNT;
   localparam int ABITS   = LOG_N - 2 - LOG_CORE_COUNT;
   localparam int BUNDLES = 1 << ABITS;
   localparam int COEFFS  = 1 << LOG_N;
   localparam int IW      = (ABITS > 0) ? ABITS : 1;
   localparam int KW      = (LOG_CORE_COUNT > 0) ? LOG_CORE_COUNT : 1;
   localparam int CW      = ABITS + 1;

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t                     state, state_next;
   logic [CORES-1:0][1:0][59:0] buffer [BUNDLES];
   logic [CW-1:0]              count, count_next;
   logic [LOG_N-1:0]           d, rd_idx;
   logic                       in_range, wr_en, load, done;
   logic [IW-1:0]              rd_addr;
   logic [KW-1:0]              rd_k;
   logic [59:0]                rd_word;
   logic [29:0]                rd_coef;

   assign in_range = 32'(in_address) < BUNDLES;

   // Read index is one ahead of the presented coefficient once the stream is live,
   // so the registered output advances on the same edge as the handshake.
   assign rd_idx  = m_valid ? d + 1'b1 : d;
   assign rd_addr = IW'(rd_idx >> (LOG_CORE_COUNT + 2));
   assign rd_k    = (LOG_CORE_COUNT > 0) ? KW'(rd_idx >> 2) : '0;
   assign rd_word = buffer[rd_addr][rd_k][rd_idx[1]];
   assign rd_coef = rd_idx[0] ? rd_word[59:30] : rd_word[29:0];

   always_comb begin
      state_next = state;
      count_next = count;
      wr_en      = 1'b0;
      load       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE, CAPTURE: begin
            if (in_active && in_range) begin
               wr_en = 1'b1;
               if (count == CW'(BUNDLES - 1)) begin
                  state_next = DRAIN;
                  count_next = '0;
               end else begin
                  state_next = CAPTURE;
                  count_next = count + 1'b1;
               end
            end
         end
         DRAIN: begin
            load = !m_valid || m_ready;
            done = m_valid && m_ready && (d == LOG_N'(COEFFS - 1));
            if (done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         count         <= '0;
         collect_ready <= 1'b1;
         overrun       <= 1'b0;
         addr_error    <= 1'b0;
      end else begin
         state         <= state_next;
         count         <= count_next;
         collect_ready <= (state_next == IDLE);
         if (state == DRAIN && in_active) overrun <= 1'b1;
         if (state != DRAIN && in_active && !in_range) addr_error <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d       <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else if (done) begin
         d       <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (load) begin
         d       <= rd_idx;
         m_valid <= 1'b1;
         m_data  <= rd_coef;
         m_last  <= (rd_idx == LOG_N'(COEFFS - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) buffer[in_address[IW-1:0]] <= in_data;
   end

endmodule
